vga_text_writer: RTL and testbench

Character-stream front end for the text-mode display. Accepts one byte at a time over a valid/ready handshake, interprets a small control-character set, and maintains a cursor. Drives the character-buffer write port (`DATA_ADDR`, `DATA_IN`, `WR_EN` of the VGA top) with cell writes and multi-cycle row and screen clears. Sits between the CPU/UART side and the VGA top, in the `pixel_clk` domain.

---
 rtl/vga_text_pkg.sv | 17 +
 rtl/vga_text_clear_seq.sv | 46 ++++
 rtl/vga_text_writer.sv | 146 ++++++++++++++
 tb/tb_vga_text_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared encodings for the text writer: FSM states, control characters, default fill byte.
package vga_text_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam logic [7:0] BLANK_DEF = 8'h20;

endpackage

// File: rtl/vga_text_clear_seq.sv
// Purpose: walks ascending addresses base..base+len-1, one per cycle, for row/screen clears.
// Latency: first address presented the cycle after start; done marks the last address.
// Backpressure: none; runs to completion once started (reset restarts a full-screen walk).
module vga_text_clear_seq #(
    parameter int ADDR_W    = 6,
    parameter int CNT_W     = 7,
    parameter int RESET_LEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  len,
    output logic              clr_vld,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    logic              active;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;

    // Reset leaves the walker armed for a whole-screen clear from address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b1;
            k      <= '0;
            len_q  <= CNT_W'(RESET_LEN);
            base_q <= '0;
        end else if (start) begin
            active <= 1'b1;
            k      <= '0;
            len_q  <= len;
            base_q <= base;
        end else if (active) begin
            if (done) active <= 1'b0;
            else      k      <= k + 1'b1;
        end
    end

    assign clr_vld  = active;
    assign clr_addr = base_q + ADDR_W'(k);
    assign done     = active && (k == len_q - 1'b1);

endmodule

// File: rtl/vga_text_writer.sv
// Purpose: byte stream to character-buffer writes with cursor, CR/LF/BS/FF handling and clears.
// Latency: cell write registered one cycle after acceptance; row clear COLS cycles, screen clear COLS*ROWS.
// Backpressure: char_ready high only in IDLE; bytes offered during a clear wait until it finishes.
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS   = 16,
    parameter int         ROWS   = 4,
    parameter int         ADDR_W = 6,
    parameter logic [7:0] BLANK  = BLANK_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               char_in,
    input  logic                     char_valid,
    output logic                     char_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [7:0]               wr_data,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic                     busy
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TOTAL = COLS * ROWS;

    state_t            state;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              accept;
    logic              is_ctrl;
    logic              col_last;
    logic [RW-1:0]     next_row;
    logic [ADDR_W-1:0] cell_addr;
    logic              clr_start;
    logic [ADDR_W-1:0] clr_base;
    logic [CNT_W-1:0]  clr_len;
    logic              clr_vld;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done;

    assign char_ready = (state == IDLE);
    assign busy       = !char_ready;
    assign accept     = char_valid && char_ready;
    assign cur_row    = row;
    assign cur_col    = col;

    assign is_ctrl   = (char_in == CH_LF) || (char_in == CH_CR) ||
                       (char_in == CH_BS) || (char_in == CH_FF);
    assign col_last  = (int'(col) == COLS - 1);
    assign next_row  = (int'(row) == ROWS - 1) ? '0 : row + 1'b1;
    assign cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    // The row clear targets the row the cursor is moving onto, not the one it leaves.
    always_comb begin
        clr_start = 1'b0;
        clr_base  = ADDR_W'(next_row) * ADDR_W'(COLS);
        clr_len   = CNT_W'(COLS);
        if (accept) begin
            if (char_in == CH_FF) begin
                clr_start = 1'b1;
                clr_base  = '0;
                clr_len   = CNT_W'(TOTAL);
            end else if (char_in == CH_LF || (!is_ctrl && col_last)) begin
                clr_start = 1'b1;
            end
        end
    end

    vga_text_clear_seq #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .RESET_LEN (TOTAL)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .start    (clr_start),
        .base     (clr_base),
        .len      (clr_len),
        .clr_vld  (clr_vld),
        .clr_addr (clr_addr),
        .done     (clr_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLR_ALL;
            row     <= '0;
            col     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (char_in)
                            CH_LF: begin
                                col   <= '0;
                                row   <= next_row;
                                state <= CLR_ROW;
                            end
                            CH_CR: col <= '0;
                            CH_BS: begin
                                if (col != '0) begin
                                    col     <= col - 1'b1;
                                    wr_en   <= 1'b1;
                                    wr_addr <= cell_addr - 1'b1;
                                    wr_data <= BLANK;
                                end
                            end
                            CH_FF: begin
                                row   <= '0;
                                col   <= '0;
                                state <= CLR_ALL;
                            end
                            default: begin
                                wr_en   <= 1'b1;
                                wr_addr <= cell_addr;
                                wr_data <= char_in;
                                if (col_last) begin
                                    col   <= '0;
                                    row   <= next_row;
                                    state <= CLR_ROW;
                                end else begin
                                    col <= col + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    wr_en   <= clr_vld;
                    wr_addr <= clr_addr;
                    wr_data <= BLANK;
                    if (clr_done) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed plus random byte stream against a screen/cursor model built from the character rules.
module tb_vga_text_writer;

    localparam int COLS = 16, ROWS = 4, ADDR_W = 6, TOTAL = COLS * ROWS;
    localparam logic [7:0] BL = 8'h20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              char_valid = 1'b0;
    logic [7:0]        char_in = 8'h00;
    logic              char_ready, wr_en, busy;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [1:0]        cur_row;
    logic [3:0]        cur_col;

    int total = 0;
    int bad   = 0;
    int wq[$];
    int eq[$];
    logic [7:0] shadow  [TOTAL];
    logic [7:0] mscreen [TOTAL];
    int mrow, mcol;

    always #5 clk = ~clk;

    vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(BL)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .busy       (busy)
    );

    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            wq.push_back(int'(wr_addr) * 256 + int'(wr_data));
            shadow[wr_addr] = wr_data;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic mwrite(input int a, input int d);
        eq.push_back(a * 256 + d);
        mscreen[a] = 8'(d);
    endtask

    task automatic mclear(input int base, input int len);
        for (int k = 0; k < len; k++) mwrite(base + k, BL);
    endtask

    task automatic mstep(input logic [7:0] b);
        if (b == 8'h0A) begin
            mcol = 0; mrow = (mrow + 1) % ROWS; mclear(mrow * COLS, COLS);
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h08) begin
            if (mcol > 0) begin mcol--; mwrite(mrow * COLS + mcol, BL); end
        end else if (b == 8'h0C) begin
            mrow = 0; mcol = 0; mclear(0, TOTAL);
        end else begin
            mwrite(mrow * COLS + mcol, b);
            mcol++;
            if (mcol == COLS) begin
                mcol = 0; mrow = (mrow + 1) % ROWS; mclear(mrow * COLS, COLS);
            end
        end
    endtask

    task automatic mreset();
        mrow = 0; mcol = 0;
        for (int i = 0; i < TOTAL; i++) mscreen[i] = BL;
        eq.delete(); wq.delete();
    endtask

    task automatic put(input logic [7:0] b, output int waited);
        waited = 0;
        @(negedge clk);
        char_in = b; char_valid = 1'b1;
        while (char_ready !== 1'b1 && waited < 200) begin
            @(negedge clk); waited++;
        end
        chk("put_timeout", int'(waited < 200), 1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        mstep(b);
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_row"}, cur_row, mrow);
        chk({tag, "_col"}, cur_col, mcol);
    endtask

    task automatic cmp_writes(input string tag);
        int n = 0;
        while (char_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk({tag, "_idle_timeout"}, int'(n < 500), 1);
        @(negedge clk);
        chk({tag, "_wr_count"}, wq.size(), eq.size());
        for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
            chk({tag, "_wr_addr"}, wq[i] / 256, eq[i] / 256);
            chk({tag, "_wr_data"}, wq[i] % 256, eq[i] % 256);
        end
        wq.delete(); eq.delete();
    endtask

    task automatic check_full_clear(input string tag);
        for (int i = 1; i <= TOTAL; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_en"},   wr_en, 1);
            chk({tag, "_addr"}, wr_addr, i - 1);
            chk({tag, "_data"}, wr_data, BL);
            chk({tag, "_rdy"},  char_ready, int'(i == TOTAL));
        end
        @(negedge clk);
        mreset();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"},   wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_ready"},   char_ready, 0);
        chk({tag, "_busy"},    busy, 1);
        chk({tag, "_row"},     cur_row, 0);
        chk({tag, "_col"},     cur_col, 0);
    endtask

    initial begin
        int w, n, s0, r, miss;
        logic [7:0] b;

        // Power-on reset and the initial full clear
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        check_full_clear("init_clr");

        // "AB" back-to-back
        put(8'h41, w); chk("ab_wait_a", w, 0);
        put(8'h42, w); chk("ab_wait_b", w, 0);
        chk_cursor("ab");
        cmp_writes("ab");

        // 16 printables from (0,0): wrap into row 1 with a row clear
        put(8'h0D, w);
        for (int i = 0; i < COLS; i++) put(8'h61 + 8'(i), w);
        chk_cursor("wrap");
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (char_ready === 1'b1) break;
            n++;
        end
        chk("wrap_ready_low", n, COLS);
        cmp_writes("wrap");

        // LF from (3,5) wraps to row 0; CR at (0,3)
        put(8'h0A, w); put(8'h0A, w);
        for (int i = 0; i < 5; i++) put(8'h30 + 8'(i), w);
        chk_cursor("at35");
        cmp_writes("at35");
        put(8'h0A, w);
        chk_cursor("lf_wrap");
        cmp_writes("lf_wrap");
        put(8'h58, w); put(8'h59, w); put(8'h5A, w);
        put(8'h0D, w);
        chk_cursor("cr");
        cmp_writes("cr");

        // BS at (2,4) and at (2,0)
        put(8'h0A, w); put(8'h0A, w);
        for (int i = 0; i < 4; i++) put(8'h77 + 8'(i), w);
        cmp_writes("pre_bs");
        put(8'h08, w);
        chk_cursor("bs");
        cmp_writes("bs");
        put(8'h0D, w);
        put(8'h08, w);
        chk_cursor("bs_col0");
        cmp_writes("bs_col0");

        // FF interrupted by reset after 10 clear writes
        put(8'h68, w); put(8'h69, w);
        cmp_writes("pre_ff");
        put(8'h0C, w);
        chk_cursor("ff");
        s0 = wq.size();
        n = 0;
        while (wq.size() < s0 + 10 && n < 200) begin @(negedge clk); n++; end
        chk("ff_ten_writes", int'(n < 200), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        chk_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        check_full_clear("re_clr");

        // Random stream
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 39));
            if (r == 0)      b = 8'h0C;
            else if (r < 4)  b = 8'h0A;
            else if (r < 7)  b = 8'h0D;
            else if (r < 12) b = 8'h08;
            else             b = 8'($urandom_range(33, 126));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            put(b, w);
            chk_cursor("rnd");
        end
        cmp_writes("rnd");
        miss = 0;
        for (int i = 0; i < TOTAL; i++) if (shadow[i] !== mscreen[i]) miss++;
        chk("rnd_screen", miss, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
